// File: rtl/pci_bus_arbiter_if.sv
// Request/grant bundle between the PCI arbiter and the board-level bus logic.
//
//   pci_int_req_direct     internal agent request, active-low
//   pci_ext_req_prev[3:0]  external requests, active-high, registered one clock earlier
//   pci_frame_prev         FRAME seen in the previous clock
//   pci_irdy_prev          IRDY seen in the previous clock
//   pci_irdy_now           IRDY this clock (combinational)
//   arbitration_enable     1 = arbitrate, 0 = revoke all grants
//   pci_int_gnt_direct_out internal agent grant, active-high
//   pci_ext_gnt_direct_out external grants, active-high
//
// modport master: the arbiter side (takes requests, drives grants).
// modport slave:  the bus side (drives requests and bus status, takes grants).
interface pci_bus_arbiter_if;
    logic       pci_int_req_direct;
    logic [3:0] pci_ext_req_prev;
    logic       pci_frame_prev;
    logic       pci_irdy_prev;
    logic       pci_irdy_now;
    logic       arbitration_enable;
    logic       pci_int_gnt_direct_out;
    logic [3:0] pci_ext_gnt_direct_out;

    modport master (
        input  pci_int_req_direct,
        input  pci_ext_req_prev,
        input  pci_frame_prev,
        input  pci_irdy_prev,
        input  pci_irdy_now,
        input  arbitration_enable,
        output pci_int_gnt_direct_out,
        output pci_ext_gnt_direct_out
    );

    modport slave (
        output pci_int_req_direct,
        output pci_ext_req_prev,
        output pci_frame_prev,
        output pci_irdy_prev,
        output pci_irdy_now,
        output arbitration_enable,
        input  pci_int_gnt_direct_out,
        input  pci_ext_gnt_direct_out
    );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: one internal agent (agent 0) and four external masters
// (agents 1..4). Round-robin priority with the current owner lowest, grant parking
// on the last owner, and one all-zero clock whenever ownership changes hands.
//
//   PCLK   PCI clock, all state changes on its rising edge
//   RST_N  asynchronous active-low reset
//   bus    request/grant bundle (pci_bus_arbiter_if.master)
module pci_bus_arbiter #(
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input logic               PCLK,
    input logic               RST_N,
    pci_bus_arbiter_if.master bus
);

    localparam int unsigned CntW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StGranted, StSwitch} state_e;

    state_e          state_q, state_d;
    logic [4:0]      gnt_q, gnt_d;
    logic [2:0]      last_q, last_d;
    logic [CntW-1:0] idle_cnt_q, idle_cnt_d;

    logic [4:0] req;
    logic       bus_busy;
    logic       others_req;
    logic       timeout;
    logic [2:0] winner;
    logic       winner_vld;
    int         idx;

    assign req        = {bus.pci_ext_req_prev, ~bus.pci_int_req_direct};
    assign bus_busy   = bus.pci_frame_prev | bus.pci_irdy_prev | bus.pci_irdy_now;
    // Only meaningful in StGranted, where gnt_q is the owner's one-hot.
    assign others_req = |(req & ~gnt_q);
    assign timeout    = (idle_cnt_q == CntW'(IDLE_TIMEOUT));

    // Rotating priority: scan from the farthest offset down so the nearest
    // requester after last_q is the one left standing.
    always_comb begin
        winner     = last_q;
        winner_vld = 1'b0;
        idx        = 0;
        for (int k = 5; k >= 1; k--) begin
            idx = (int'(last_q) + k) % 5;
            if (req[idx]) begin
                winner     = 3'(idx);
                winner_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        idle_cnt_d = '0;
        unique case (state_q)
            // Idle and the post-handoff dead clock arbitrate identically.
            StIdle, StSwitch: begin
                gnt_d   = '0;
                state_d = StIdle;
                if (bus.arbitration_enable && winner_vld) begin
                    gnt_d   = 5'd1 << winner;
                    last_d  = winner;
                    state_d = StGranted;
                end
            end
            StGranted: begin
                if (others_req && !bus_busy) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
                if (!bus.arbitration_enable) begin
                    gnt_d      = '0;
                    idle_cnt_d = '0;
                    state_d    = StIdle;
                end else if (others_req || timeout) begin
                    // Hidden handoff: the transaction in flight continues on the bus.
                    gnt_d      = '0;
                    idle_cnt_d = '0;
                    state_d    = StSwitch;
                end
                // Otherwise the owner keeps (or parks on) its grant.
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            last_q     <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign bus.pci_int_gnt_direct_out = gnt_q[0];
    assign bus.pci_ext_gnt_direct_out = gnt_q[4:1];

endmodule

// File: tb/tb_pci_bus_arbiter.sv
module tb_pci_bus_arbiter;

    logic PCLK;
    logic RST_N;
    pci_bus_arbiter_if bus ();

    pci_bus_arbiter #(
        .IDLE_TIMEOUT(16)
    ) dut (
        .PCLK (PCLK),
        .RST_N(RST_N),
        .bus  (bus.master)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    function automatic logic [4:0] g();
        return {bus.pci_ext_gnt_direct_out, bus.pci_int_gnt_direct_out};
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus (-1 = nobody) and who last won. Any clock with no
    // owner arbitrates; any other requester takes an owner's grant away.
    int m_owner;
    int m_last;

    function automatic int pick_next(input logic [4:0] r, input int last);
        for (int k = 1; k <= 5; k++) begin
            if (r[(last + k) % 5]) return (last + k) % 5;
        end
        return -1;
    endfunction

    function automatic logic [4:0] cur_req();
        return {bus.pci_ext_req_prev, ~bus.pci_int_req_direct};
    endfunction

    always @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            m_owner <= -1;
            m_last  <= 0;
        end else if (m_owner >= 0) begin
            if (!bus.arbitration_enable) begin
                m_owner <= -1;
            end else if ((cur_req() & ~(5'd1 << m_owner)) != 5'd0) begin
                m_owner <= -1;
            end
        end else if (bus.arbitration_enable && pick_next(cur_req(), m_last) >= 0) begin
            m_owner <= pick_next(cur_req(), m_last);
            m_last  <= pick_next(cur_req(), m_last);
        end
    end

    always @(negedge PCLK) begin
        if (cmp_on) begin
            chk("model", g(), (m_owner < 0) ? 5'd0 : 5'(5'd1 << m_owner));
        end
    end

    int cnt [5];

    initial begin
        RST_N                  = 1'b0;
        bus.pci_int_req_direct = 1'b1;
        bus.pci_ext_req_prev   = 4'b0000;
        bus.pci_frame_prev     = 1'b0;
        bus.pci_irdy_prev      = 1'b0;
        bus.pci_irdy_now       = 1'b0;
        bus.arbitration_enable = 1'b1;
        repeat (2) @(negedge PCLK);
        chk("reset_gnt", g(), 5'b00000);
        RST_N  = 1'b1;
        cmp_on = 1'b1;

        // Single requester: grant next clock, held, then parked.
        bus.pci_ext_req_prev = 4'b0001;
        @(negedge PCLK) chk("t1_grant", g(), 5'b00010);
        repeat (3) begin
            @(negedge PCLK) chk("t1_hold", g(), 5'b00010);
        end
        bus.pci_ext_req_prev = 4'b0000;
        repeat (2) @(negedge PCLK);
        chk("t1_park", g(), 5'b00010);

        // Two requesters alternate with a dead clock between.
        bus.pci_ext_req_prev = 4'b0101;
        @(negedge PCLK) chk("t2_dead0", g(), 5'b00000);
        @(negedge PCLK) chk("t2_ext2", g(), 5'b01000);
        @(negedge PCLK) chk("t2_dead1", g(), 5'b00000);
        @(negedge PCLK) chk("t2_ext0", g(), 5'b00010);

        // Ext agent 1 owns a busy bus, then the internal agent asks.
        bus.pci_ext_req_prev = 4'b0010;
        bus.pci_frame_prev   = 1'b1;
        bus.pci_irdy_now     = 1'b1;
        @(negedge PCLK) chk("t3_dead0", g(), 5'b00000);
        @(negedge PCLK) chk("t3_ext1", g(), 5'b00100);
        bus.pci_int_req_direct = 1'b0;
        @(negedge PCLK) chk("t3_drop", g(), 5'b00000);
        @(negedge PCLK) chk("t3_int", g(), 5'b00001);
        bus.pci_frame_prev     = 1'b0;
        bus.pci_irdy_now       = 1'b0;
        bus.pci_ext_req_prev   = 4'b0000;
        bus.pci_int_req_direct = 1'b1;
        repeat (2) @(negedge PCLK);
        chk("t3_park", g(), 5'b00001);

        // Disable revokes; re-enable with a pending request grants next clock.
        bus.arbitration_enable = 1'b0;
        @(negedge PCLK) chk("t4_off", g(), 5'b00000);
        bus.pci_ext_req_prev = 4'b1000;
        @(negedge PCLK) chk("t4_off_req", g(), 5'b00000);
        bus.arbitration_enable = 1'b1;
        @(negedge PCLK) chk("t4_on", g(), 5'b10000);

        // All five request: each granted exactly once per 10-clock round.
        bus.pci_int_req_direct = 1'b0;
        bus.pci_ext_req_prev   = 4'b1111;
        @(negedge PCLK) chk("t5_dead", g(), 5'b00000);
        for (int a = 0; a < 5; a++) cnt[a] = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge PCLK);
            if (c == 0) chk("t5_first", g(), 5'b00001);
            for (int a = 0; a < 5; a++) begin
                if (g()[a]) cnt[a]++;
            end
        end
        for (int a = 0; a < 5; a++) begin
            chk($sformatf("t5_round_agent%0d", a), 5'(cnt[a]), 5'd1);
        end

        // Reset mid-grant drops outputs at once; afterwards agent 1 wins first.
        @(negedge PCLK) chk("t6_pre", g(), 5'b00001);
        #2 RST_N = 1'b0;
        #1 chk("t6_async", g(), 5'b00000);
        @(negedge PCLK);
        RST_N = 1'b1;
        @(negedge PCLK) chk("t6_first", g(), 5'b00010);
        repeat (6) @(negedge PCLK);

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
